// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin N-to-1 CBus arbiter granting whole transactions
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  localparam logic [3:0] LEN1 = 4'd0, LEN2 = 4'd1, LEN4 = 4'd3, LEN8 = 4'd7, LEN16 = 4'd15;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int SW = $clog2(NUM_INPUTS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t        r_state;
  logic [SW-1:0] r_sel, r_prio, w_pick, w_idx;
  logic          w_any;
  // first valid requester scanning from r_prio upward, wrapping at NUM_INPUTS
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_prio;
    w_idx  = r_prio;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      w_idx = SW'((int'(r_prio) + k) % NUM_INPUTS);
      if (ireqs[w_idx].valid) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end
  // grant one whole transaction; rotate priority past the winner when it ends
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_prio  <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_sel   <= w_pick;
        r_state <= BUSY;
      end
    end else if (oresp.ready && oresp.last) begin
      r_state <= IDLE;
      r_prio  <= (r_sel == SW'(NUM_INPUTS - 1)) ? '0 : r_sel + 1'b1;
    end
  end
  // pass the granted request through and route the response back only to it
  always_comb begin
    oreq = (r_state == BUSY) ? ireqs[r_sel] : '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      iresps[i] = (r_state == BUSY && r_sel == SW'(i)) ? oresp : '0;
  end
  // a granted requester must hold valid until it has seen ready && last
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    r_state == BUSY |-> ireqs[r_sel].valid);
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: table-driven scoreboard bench for cbus_arbiter
module tb_cbus_arbiter;
  import cbus_pkg::*;
  localparam int N = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit v0; bit v1; bit rdy; bit lst; int g;
  } vec_t;
  typedef struct {
    cbus_req_t  oreq;
    cbus_resp_t r0;
    cbus_resp_t r1;
  } exp_t;

  exp_t      sbq[$];
  vec_t      tbl[30];
  int        checks = 0;
  int        errors = 0;
  cbus_req_t req0, req1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic run_row(vec_t v, int n);
    exp_t       e;
    cbus_resp_t rs;
    @(negedge clk);
    reset    = v.rst;
    ireqs[0] = v.v0 ? req0 : '0;
    ireqs[1] = v.v1 ? req1 : '0;
    rs       = '0;
    rs.ready = v.rdy;
    rs.last  = v.lst;
    rs.data  = 32'hd000_0000 + 32'(n);
    oresp    = rs;
    e.oreq   = (v.g == 0) ? req0 : (v.g == 1) ? req1 : '0;
    e.r0     = (v.g == 0) ? rs : '0;
    e.r1     = (v.g == 1) ? rs : '0;
    sbq.push_back(e);
    #2;
    e = sbq.pop_front();
    chk($sformatf("row%0d oreq", n), 128'(oreq), 128'(e.oreq));
    chk($sformatf("row%0d iresp0", n), 128'(iresps[0]), 128'(e.r0));
    chk($sformatf("row%0d iresp1", n), 128'(iresps[1]), 128'(e.r1));
  endtask

  initial begin
    int lat;
    req0 = '0; req0.valid = 1'b1; req0.size = 3'd2; req0.addr = 32'h1fc0_0000; req0.len = LEN4;
    req1 = '0; req1.valid = 1'b1; req1.is_write = 1'b1; req1.size = 3'd2;
    req1.addr = 32'hbfaf_8000; req1.strobe = 4'b0011; req1.data = 32'h1234_abcd; req1.len = LEN1;
    ireqs[0] = '0; ireqs[1] = '0; oresp = '0;
    // single requester: 4 beats with one stall, last on beat 4
    tbl[0]  = '{0,1,0,0,0,-1};
    tbl[1]  = '{0,1,0,1,0,0};
    tbl[2]  = '{0,1,0,1,0,0};
    tbl[3]  = '{0,1,0,0,0,0};
    tbl[4]  = '{0,1,0,1,0,0};
    tbl[5]  = '{0,1,0,1,1,0};
    tbl[6]  = '{0,0,0,0,0,-1};
    // reset, then contention and fairness 0,1,0,1
    tbl[7]  = '{1,0,0,0,0,-1};
    tbl[8]  = '{0,1,1,0,0,-1};
    tbl[9]  = '{0,1,1,0,0,0};
    tbl[10] = '{0,1,1,1,1,0};
    tbl[11] = '{0,1,1,0,0,-1};
    tbl[12] = '{0,1,1,1,1,1};
    tbl[13] = '{0,1,1,0,0,-1};
    tbl[14] = '{0,1,1,1,1,0};
    tbl[15] = '{0,1,1,0,0,-1};
    tbl[16] = '{0,1,1,1,1,1};
    // back-to-back from port 0 alone
    tbl[17] = '{0,1,0,0,0,-1};
    tbl[18] = '{0,1,0,1,1,0};
    tbl[19] = '{0,1,0,0,0,-1};
    tbl[20] = '{0,1,0,1,1,0};
    tbl[21] = '{0,0,0,0,0,-1};
    // reset on beat 2 while prio=1; afterwards port 0 must win (prio back to 0)
    tbl[22] = '{0,1,0,0,0,-1};
    tbl[23] = '{0,1,0,1,0,0};
    tbl[24] = '{1,1,0,1,0,0};
    tbl[25] = '{0,1,1,0,0,-1};
    tbl[26] = '{0,1,1,1,1,0};
    // single-beat write pass-through on port 1
    tbl[27] = '{0,0,1,0,0,-1};
    tbl[28] = '{0,0,1,1,1,1};
    tbl[29] = '{0,0,0,0,0,-1};
    repeat (2) @(negedge clk);
    #2;
    chk("reset oreq", 128'(oreq), 128'(0));
    chk("reset iresp0", 128'(iresps[0]), 128'(0));
    chk("reset iresp1", 128'(iresps[1]), 128'(0));
    for (int i = 0; i < 30; i++) run_row(tbl[i], i);
    // latency: port 1 alone, oreq.valid exactly one cycle after valid rises
    @(negedge clk);
    ireqs[1] = req1; oresp = '0;
    #2;
    chk("lat idle", 128'(oreq.valid), 128'(0));
    lat = 0;
    for (int c = 0; c < 8 && !oreq.valid; c++) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("lat cycles", 128'(lat), 128'(1));
    // port 0 arrives while busy; ready without last keeps port 1 granted
    ireqs[0] = req0;
    oresp.ready = 1'b1; oresp.data = 32'hcafe_0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2;
      chk("busy r1 ready", 128'(iresps[1].ready), 128'(1));
      chk("busy r0 zero", 128'(iresps[0]), 128'(0));
    end
    oresp.last = 1'b1;
    @(negedge clk);
    ireqs[1] = '0; oresp = '0;
    #2;
    chk("gap idle", 128'(oreq.valid), 128'(0));
    @(negedge clk);
    #2;
    chk("late grant", 128'(oreq), 128'(req0));
    oresp.ready = 1'b1; oresp.last = 1'b1;
    @(negedge clk);
    ireqs[0] = '0; oresp = '0;
    #2;
    chk("final idle", 128'(oreq.valid), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
